acc_alu: RTL
============

Name: acc_alu

Overview:
- Accumulator-based ALU stage directly downstream of the 9-way operand select.
- Consumes the selected 8-bit operand and combines it with an internal accumulator under a 3-bit opcode.
- Single-cycle logic and add/sub ops; multi-cycle shift-add multiply.
- Start/busy/done handshake to the control sequencer; registered flags feed branch decisions.

Parameters:
- WIDTH, 8, data width of operand and accumulator; multiply takes WIDTH cycles.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  3  opcode, captured with start
- operand  input  WIDTH  selected operand from the operand mux, captured with start
- acc  output  WIDTH  accumulator (low byte of product for MUL)
- acc_hi  output  WIDTH  high byte of last MUL product; cleared by any non-MUL op except NOP
- zero  output  1  registered zero flag
- carry  output  1  registered carry/borrow flag
- busy  output  1  high while MUL in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Clocking: one clock (clk); reset is asynchronous and active-high (rst).
- Reset: acc=0, acc_hi=0, zero=0, carry=0, busy=0, done=0, FSM=IDLE. Reset asserted mid-MUL aborts the operation immediately; no done pulse follows.
- FSM states: IDLE, MUL.
  - IDLE -> MUL on start with op=110.
  - MUL -> IDLE after WIDTH iterations.
  - All other ops stay in IDLE.
- Capture: op and operand are registered on the start edge. Later changes to operand or op are ignored until the next accepted start.
- Start while busy=1 is ignored; it is not queued.
- Single-cycle ops: start high at edge N updates acc and flags at edge N. done=1 for the cycle after edge N. busy stays 0.
- Opcodes:
  - 000 LOAD: acc=operand; carry unchanged.
  - 001 ADD: {carry,acc}=acc+operand, WIDTH+1-bit sum.
  - 010 SUB: acc=acc-operand mod 2^WIDTH; carry=1 when operand>acc (borrow).
  - 011 AND, 100 OR, 101 XOR: bitwise; carry=0.
  - 110 MUL: unsigned acc*operand -> {acc_hi,acc}.
  - 111 NOP: no state change except the done pulse; zero unchanged.
- zero: set to (acc result==0) for ops 000-101. For MUL, zero is set when the full 2*WIDTH product==0.
- MUL timing:
  - Start edge N: busy=1, multiplicand=acc, multiplier=operand, partial product cleared.
  - Each of the following WIDTH edges performs one shift-add step.
  - At edge N+WIDTH: result written, busy=0, done=1 for one cycle.
  - busy is high during cycles N+1..N+WIDTH.
  - carry=1 when acc_hi!=0 after MUL.
- Back-to-back ops: start may be held high continuously in IDLE; each edge with start=1 in IDLE launches a new op. done pulses therefore appear on consecutive cycles.
- acc and acc_hi are held (not updated) during MUL; only internal shift registers change.

Optional Feature:
- Macro: ACC_ALU_SAT_EN
- Defined:
  - ADD saturates acc to all-ones on unsigned overflow.
  - SUB saturates acc to 0 on borrow.
  - carry still reports the overflow/borrow event.
- Not defined: ADD and SUB wrap modulo 2^WIDTH, as specified above.
- All other ops are identical in both builds.

Test Plan:
- Reset, then LOAD 0x3C -> acc=0x3C, zero=0, carry=0, done high exactly one cycle, busy never high.
- LOAD 0xF0; ADD 0x20 -> acc=0x10, carry=1 (with ACC_ALU_SAT_EN: acc=0xFF, carry=1). Then SUB 0x10 from acc=0x10 -> acc=0x00, zero=1, carry=0.
- LOAD 0x05; SUB 0x07 -> acc=0xFE, carry=1 (SAT build: acc=0x00, carry=1). Then XOR 0xFE from 0xFE -> acc=0x00, zero=1, carry=0.
- LOAD 0xC8; MUL 0x0F -> busy high 8 cycles, then {acc_hi,acc}=0x0BB8, carry=1, zero=0, done one pulse. A start pulse injected mid-MUL has no effect; operand changed after the start edge does not alter the result.
- LOAD 0xFF; start MUL 0xFF, assert rst at 4th busy cycle -> all outputs 0 immediately, no done. Next LOAD 0x01 after reset release behaves normally.
- start held high with op sequence LOAD 0x01, ADD 0x01, ADD 0x01, NOP on consecutive cycles -> acc 0x01, 0x02, 0x03, 0x03; done high four consecutive cycles.

Source files
------------

// File: rtl/acc_alu.sv
// Accumulator ALU with single-cycle logic/add/sub and a WIDTH-cycle shift-add multiply.
// Optional build macro ACC_ALU_SAT_EN: ADD/SUB saturate instead of wrapping.
module acc_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] acc_hi,
   output logic             zero,
   output logic             carry,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef ACC_ALU_SAT_EN
   localparam logic SAT = 1'b1;
`else
   localparam logic SAT = 1'b0;
`endif

   typedef enum logic {IDLE, MUL} state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   acc_reg, acc_next;
   logic [WIDTH-1:0]   hi_reg, hi_next;
   logic               zero_reg, zero_next;
   logic               carry_reg, carry_next;
   logic               done_reg, done_next;
   logic [2*WIDTH-1:0] mcand_reg, mcand_next;
   logic [WIDTH-1:0]   mplier_reg, mplier_next;
   logic [2*WIDTH-1:0] prod_reg, prod_next;
   logic [CW-1:0]      count_reg, count_next;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] step_prod;
   logic [WIDTH-1:0]   logic_res;

   assign sum       = {1'b0, acc_reg} + {1'b0, operand};
   // MSB of the extended difference is the borrow (operand > acc)
   assign diff      = {1'b0, acc_reg} - {1'b0, operand};
   assign step_prod = prod_reg + (mplier_reg[0] ? mcand_reg : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         acc_reg    <= '0;
         hi_reg     <= '0;
         zero_reg   <= 1'b0;
         carry_reg  <= 1'b0;
         done_reg   <= 1'b0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         prod_reg   <= '0;
         count_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         acc_reg    <= acc_next;
         hi_reg     <= hi_next;
         zero_reg   <= zero_next;
         carry_reg  <= carry_next;
         done_reg   <= done_next;
         mcand_reg  <= mcand_next;
         mplier_reg <= mplier_next;
         prod_reg   <= prod_next;
         count_reg  <= count_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      acc_next    = acc_reg;
      hi_next     = hi_reg;
      zero_next   = zero_reg;
      carry_next  = carry_reg;
      done_next   = 1'b0;
      mcand_next  = mcand_reg;
      mplier_next = mplier_reg;
      prod_next   = prod_reg;
      count_next  = count_reg;
      logic_res   = '0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               done_next = 1'b1;
               case (op)
                  OP_LOAD: begin
                     acc_next  = operand;
                     hi_next   = '0;
                     zero_next = (operand == '0);
                  end
                  OP_ADD: begin
                     acc_next   = (SAT && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
                     hi_next    = '0;
                     carry_next = sum[WIDTH];
                     zero_next  = (acc_next == '0);
                  end
                  OP_SUB: begin
                     acc_next   = (SAT && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
                     hi_next    = '0;
                     carry_next = diff[WIDTH];
                     zero_next  = (acc_next == '0);
                  end
                  OP_AND, OP_OR, OP_XOR: begin
                     if (op == OP_AND)
                        logic_res = acc_reg & operand;
                     else if (op == OP_OR)
                        logic_res = acc_reg | operand;
                     else
                        logic_res = acc_reg ^ operand;
                     acc_next   = logic_res;
                     hi_next    = '0;
                     carry_next = 1'b0;
                     zero_next  = (logic_res == '0);
                  end
                  OP_MUL: begin
                     // done is deferred to the final shift-add step
                     done_next   = 1'b0;
                     state_next  = MUL;
                     mcand_next  = {{WIDTH{1'b0}}, acc_reg};
                     mplier_next = operand;
                     prod_next   = '0;
                     count_next  = '0;
                  end
                  default: ;
               endcase
            end
         end
         MUL: begin
            prod_next   = step_prod;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            count_next  = count_reg + 1'b1;
            if (count_reg == CW'(WIDTH - 1)) begin
               state_next = IDLE;
               acc_next   = step_prod[WIDTH-1:0];
               hi_next    = step_prod[2*WIDTH-1:WIDTH];
               zero_next  = (step_prod == '0);
               carry_next = |step_prod[2*WIDTH-1:WIDTH];
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign acc    = acc_reg;
   assign acc_hi = hi_reg;
   assign zero   = zero_reg;
   assign carry  = carry_reg;
   assign busy   = (state_reg == MUL);
   assign done   = done_reg;

endmodule
